// File: rtl/en_burst_gen.sv
// Enable-pulse burst generator: on an accepted start it issues burst_len single-cycle
// en pulses spaced period idle cycles apart, then strobes done for one cycle.
module en_burst_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] period,
    input  logic [W-1:0] burst_len,
    output logic         en,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state, state_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] len_q, len_d;
    logic [W-1:0] cnt_d;
    logic [W-1:0] wait_cnt, wait_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state;
        period_d = period_q;
        len_d    = len_q;
        cnt_d    = pulse_cnt;
        wait_d   = wait_cnt;
        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && !stop) begin
                    period_d = period;
                    len_d    = burst_len;
                    cnt_d    = '0;
                    state_d  = (burst_len != '0) ? PULSE : DONE;
                end
            end
            PULSE: begin
                // The pulse in this cycle is counted even when it is being aborted.
                cnt_d = pulse_cnt + W'(1);
                if (stop)                  state_d = IDLE;
                else if (cnt_d == len_q)   state_d = DONE;
                else if (period_q == '0)   state_d = PULSE;
                else begin
                    wait_d  = period_q - W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (stop)                  state_d = IDLE;
                else if (wait_cnt == '0)   state_d = PULSE;
                else                       wait_d  = wait_cnt - W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state     <= IDLE;
            period_q  <= '0;
            len_q     <= '0;
            pulse_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_d;
            period_q  <= period_d;
            len_q     <= len_d;
            pulse_cnt <= cnt_d;
            wait_cnt  <= wait_d;
        end
    end

    assign en   = (state == PULSE);
    assign busy = (state == PULSE) || (state == WAIT);
    assign done = (state == DONE);

endmodule
